gpio_vector_gen: RTL

Hardware pattern source for the openframe user project. It drives an incrementing count onto a contiguous field of the GPIO output vector so that a board-level or testbench monitor can watch a known sequence. Each value is held for a programmable number of clocks. The block counts from 0 to a programmable end value, then stops or loops. Outside the driven field, all pads stay tri-stated. The block sits between the project's control logic and the gpio_out/gpio_oeb pad bus.

---
 rtl/gpio_vector_gen_if.sv | 28 ++
 rtl/gpio_vector_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/gpio_vector_gen_if.sv
// Control and pad-bus bundle for gpio_vector_gen.
// master: the control logic / bench side; slave: the pattern generator.
interface gpio_vector_gen_if #(
    parameter int unsigned NGPIO  = 44,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HOLD_W = 16
);
    logic              start;
    logic              stop;
    logic              loop;
    logic [HOLD_W-1:0] hold_cycles;
    logic [WIDTH-1:0]  end_value;
    logic [NGPIO-1:0]  gpio_out;
    logic [NGPIO-1:0]  gpio_oeb;
    logic [WIDTH-1:0]  value;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, loop, hold_cycles, end_value,
        input  gpio_out, gpio_oeb, value, busy, done
    );

    modport slave (
        input  start, stop, loop, hold_cycles, end_value,
        output gpio_out, gpio_oeb, value, busy, done
    );
endinterface

// File: rtl/gpio_vector_gen.sv
// Pattern source: drives an incrementing count onto a GPIO field, holding
// each value for a programmable number of clocks, counting 0..end_value and
// then stopping or looping. Pads outside the field are always tri-stated.
module gpio_vector_gen #(
    parameter int unsigned NGPIO     = 44,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FIELD_LSB = 16,
    parameter int unsigned HOLD_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    gpio_vector_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [HOLD_W-1:0] cnt_q,   cnt_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [WIDTH-1:0]  end_q,   end_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              oe_q,    oe_d;

    logic [HOLD_W-1:0] hold_eff;
    logic              expire;

    // Zero hold is treated as one clock per value.
    assign hold_eff = (bus.hold_cycles == '0) ? HOLD_W'(1) : bus.hold_cycles;
    assign expire   = (cnt_q <= HOLD_W'(1));

    // Next-state and next-output computation; stop overrides everything.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        end_d   = end_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    hold_d  = hold_eff;
                    end_d   = bus.end_value;
                    value_d = '0;
                    cnt_d   = hold_eff;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = RUN;
            end
            RUN: begin
                if (expire) begin
                    if (value_q == end_q) begin
                        state_d = DONE;
                    end else begin
                        value_d = value_q + WIDTH'(1);
                        cnt_d   = hold_q;
                    end
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            DONE: begin
                if (bus.start) begin
                    hold_d  = hold_eff;
                    end_d   = bus.end_value;
                    value_d = '0;
                    cnt_d   = hold_eff;
                    state_d = SETUP;
                end else if (bus.loop) begin
                    value_d = '0;
                    cnt_d   = hold_q;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                value_d = '0;
            end
        endcase

        if (bus.stop) begin
            state_d = IDLE;
            value_d = '0;
            cnt_d   = '0;
        end

        // Status flags follow the next state so they are registered with it.
        busy_d = (state_d == SETUP) || (state_d == RUN);
        done_d = (state_d == DONE);
        oe_d   = (state_d != IDLE);
    end

    // State, counters, latched configuration and registered status.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            value_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            end_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            oe_q    <= oe_d;
        end
    end

    logic [NGPIO-1:0] pad_out;
    logic [NGPIO-1:0] pad_oeb;

    // Pad vectors: only the field carries data; everything else stays tri-stated.
    always_comb begin
        pad_out = '0;
        pad_oeb = '1;
        pad_out[FIELD_LSB +: WIDTH] = value_q;
        pad_oeb[FIELD_LSB +: WIDTH] = {WIDTH{~oe_q}};
    end

    assign bus.gpio_out = pad_out;
    assign bus.gpio_oeb = pad_oeb;
    assign bus.value    = value_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
